mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 52 +++++
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle of every handshake and data signal of the memory access unit.
// The "master" modport is the unit itself: it drives the data-cache request
// and the writeback port, and it is the ready side of the execute handshake.
// The "slave" modport is the surrounding pipeline and cache. It presents ops,
// accepts cache requests and returns load data.
interface mem_access_unit_if;
  // execute -> unit
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_store;
  logic [4:0]  rd;

  // unit -> data cache
  logic        req_valid;
  logic        req_ready;
  logic [29:0] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;

  // data cache -> unit
  logic        resp_valid;
  logic [31:0] resp_data;

  // unit -> writeback
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;

  modport master (
    input  in_valid, alu_out, store_data, funct3, is_load, is_store, rd,
    output in_ready,
    output req_valid, req_addr, req_wmask, req_wdata,
    input  req_ready,
    input  resp_valid, resp_data,
    output wb_valid, wb_we, wb_rd, wb_data, misaligned
  );

  modport slave (
    output in_valid, alu_out, store_data, funct3, is_load, is_store, rd,
    input  in_ready,
    input  req_valid, req_addr, req_wmask, req_wdata,
    output req_ready,
    output resp_valid, resp_data,
    input  wb_valid, wb_we, wb_rd, wb_data, misaligned
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access stage of an RV32I pipeline. The unit takes one op at a time
// from execute. It issues an aligned load or store to the data cache and
// waits for load data. It then retires the op to writeback with a one-cycle
// pulse. Misaligned accesses and unsupported encodings never reach the cache.
// They retire at once, with the misaligned flag set.
module mem_access_unit (
  input  logic              clk,
  input  logic              reset_n,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t state, state_next;

  // Decode of the op presented by execute.
  logic        is_mem;
  logic        unsupported;
  logic        misalign;
  logic        bad_access;
  logic        accept;
  logic [3:0]  store_mask;
  logic [31:0] store_lanes;

  // Op context captured at acceptance.
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        we_q;
  logic        mis_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [29:0] req_addr_q;
  logic [3:0]  req_wmask_q;
  logic [31:0] req_wdata_q;

  // Load data after lane selection and extension.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  // Classify the incoming op: memory or not, legal encoding, alignment.
  always_comb begin
    is_mem      = bus.is_load | bus.is_store;
    unsupported = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                  (bus.funct3 == 3'b111);
    misalign    = ((bus.funct3[1:0] == SIZE_HALF) && bus.alu_out[0]) ||
                  ((bus.funct3[1:0] == SIZE_WORD) && (bus.alu_out[1:0] != 2'b00));
    bad_access  = is_mem && (unsupported || misalign);
    accept      = bus.in_valid && (state == IDLE);
  end

  // Move store data onto its byte lanes and build the byte write mask.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that
    // skips an assignment would otherwise infer a latch.
    store_mask  = 4'b0000;
    store_lanes = bus.store_data;
    if (bus.is_store) begin
      unique case (bus.funct3[1:0])
        SIZE_BYTE: begin
          store_mask  = 4'b0001 << bus.alu_out[1:0];
          store_lanes = {4{bus.store_data[7:0]}};
        end
        SIZE_HALF: begin
          store_mask  = bus.alu_out[1] ? 4'b1100 : 4'b0011;
          store_lanes = {2{bus.store_data[15:0]}};
        end
        default: begin
          store_mask  = 4'b1111;
          store_lanes = bus.store_data;
        end
      endcase
    end
  end

  // Pick the addressed byte or halfword from the returned word and extend it.
  always_comb begin
    unique case (addr_lo_q)
      2'd0:    load_byte = bus.resp_data[7:0];
      2'd1:    load_byte = bus.resp_data[15:8];
      2'd2:    load_byte = bus.resp_data[23:16];
      default: load_byte = bus.resp_data[31:24];
    endcase
    load_half = addr_lo_q[1] ? bus.resp_data[31:16] : bus.resp_data[15:0];
    unique case (funct3_q)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_value = {24'd0, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = bus.resp_data;
    endcase
  end

  // State register. Reset drops any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment, so every flop
    // samples the values from before the edge.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and the handshake and writeback strobes. Every strobe
  // decodes from the registered state only.
  always_comb begin
    state_next     = state;
    bus.in_ready   = 1'b0;
    bus.req_valid  = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.wb_we      = 1'b0;
    bus.misaligned = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = (is_mem && !bad_access) ? REQ : DONE;
      end
      REQ: begin
        bus.req_valid = 1'b1;
        if (bus.req_ready) state_next = load_q ? WAIT : DONE;
      end
      WAIT: begin
        if (bus.resp_valid) state_next = DONE;
      end
      DONE: begin
        bus.wb_valid   = 1'b1;
        bus.wb_we      = we_q;
        bus.misaligned = mis_q;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the op context on acceptance. Load data is captured when the
  // cache responds.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the datapath registers are reset as well as the FSM. They drive
    // output ports directly, and those ports must read zero after reset.
    if (!reset_n) begin
      load_q      <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      req_addr_q  <= 30'd0;
      req_wmask_q <= 4'd0;
      req_wdata_q <= 32'd0;
    end else if (accept) begin
      load_q      <= bus.is_load;
      funct3_q    <= bus.funct3;
      addr_lo_q   <= bus.alu_out[1:0];
      // Stores and rejected ops never write the register file. A load to
      // x0 still goes to the cache but its result is dropped.
      we_q        <= (bus.rd != 5'd0) && !bad_access && !bus.is_store;
      mis_q       <= bad_access;
      wb_rd_q     <= bus.rd;
      wb_data_q   <= bus.alu_out;
      req_addr_q  <= bus.alu_out[31:2];
      req_wmask_q <= store_mask;
      req_wdata_q <= store_lanes;
    end else if ((state == WAIT) && bus.resp_valid) begin
      wb_data_q   <= load_value;
    end
  end

  assign bus.req_addr  = req_addr_q;
  assign bus.req_wmask = req_wmask_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. A table of ops is applied one at a time.
// The expected retirement of each op goes into a scoreboard queue when the op
// is driven, and a monitor pops and compares it when wb_valid pulses. Cache
// request contents are checked while the request is held. Hand-written
// sequences cover reset behaviour.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] resp;
    int          ready_dly;
    int          resp_dly;
    logic        exp_req;
    logic [29:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_mis;
    logic [31:0] exp_data;
    logic        chk_data;
  } vec_t;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
  } exp_wb_t;

  exp_wb_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writeback monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.wb_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d, expected no retirement", bus.wb_rd);
        end else begin
          exp_wb_t e;
          e = sb_q.pop_front();
          check({e.name, "_wb_we"},      32'(bus.wb_we),      32'(e.we));
          check({e.name, "_wb_rd"},      32'(bus.wb_rd),      32'(e.rd));
          check({e.name, "_misaligned"}, 32'(bus.misaligned), 32'(e.mis));
          check({e.name, "_done_noreq"}, 32'(bus.req_valid),  32'd0);
          check({e.name, "_done_busy"},  32'(bus.in_ready),   32'd0);
          if (e.chk_data) check({e.name, "_wb_data"}, bus.wb_data, e.data);
        end
      end else begin
        check("mis_outside_done", 32'(bus.misaligned), 32'd0);
        check("we_outside_done",  32'(bus.wb_we),      32'd0);
      end
    end
  end

  // Apply one op from the table, acting as the cache side as well.
  task automatic apply(input vec_t v);
    exp_wb_t e;
    check({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.is_load    = v.is_load;
    bus.is_store   = v.is_store;
    bus.funct3     = v.funct3;
    bus.alu_out    = v.addr;
    bus.store_data = v.sdata;
    bus.rd         = v.rd;
    e = '{name: v.name, we: v.exp_we, rd: v.rd, data: v.exp_data,
          chk_data: v.chk_data, mis: v.exp_mis};
    sb_q.push_back(e);
    tick();
    // Scramble the inputs so the bench sees whether the unit really captured them.
    bus.in_valid   = 1'b0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.alu_out    = $urandom;
    bus.store_data = $urandom;
    bus.rd         = 5'($urandom);
    if (v.exp_req) begin
      for (int i = 0; i <= v.ready_dly; i++) begin
        check({v.name, "_req_valid"}, 32'(bus.req_valid), 32'd1);
        check({v.name, "_req_addr"},  32'(bus.req_addr),  32'(v.exp_addr));
        check({v.name, "_req_wmask"}, 32'(bus.req_wmask), 32'(v.exp_mask));
        if (v.is_store) check({v.name, "_req_wdata"}, bus.req_wdata, v.exp_wdata);
        check({v.name, "_req_busy"}, 32'(bus.in_ready), 32'd0);
        if (i == v.ready_dly) bus.req_ready = 1'b1;
        tick();
      end
      bus.req_ready = 1'b0;
      if (v.is_load) begin
        for (int i = 0; i <= v.resp_dly; i++) begin
          check({v.name, "_wait_busy"},  32'(bus.in_ready),  32'd0);
          check({v.name, "_wait_noreq"}, 32'(bus.req_valid), 32'd0);
          if (i == v.resp_dly) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = v.resp;
          end else begin
            bus.resp_data  = $urandom;
          end
          tick();
        end
        bus.resp_valid = 1'b0;
      end
    end else begin
      check({v.name, "_no_req"}, 32'(bus.req_valid), 32'd0);
    end
    // Bounded wait for the monitor to consume this op.
    for (int k = 0; k < 8; k++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending retirements, expected 0", v.name, sb_q.size());
      sb_q.delete();
    end
  endtask

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            name         ld    st    f3      addr          sdata         rd     resp          rdy pdly req  exp_addr  mask     wdata         we    mis   data          chk
    vecs[0]  = '{"alu_basic",  1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        5'd5,  32'h0,        0, 0, 1'b0, 30'h0,   4'b0000, 32'h0,        1'b1, 1'b0, 32'h0000_1234, 1'b1};
    vecs[1]  = '{"alu_rd0",    1'b0, 1'b0, 3'b111, 32'hDEAD_BEEF, 32'h0,        5'd0,  32'h0,        0, 0, 1'b0, 30'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[2]  = '{"lb_103",     1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd3,  32'h80FF_0000, 2, 0, 1'b1, 30'h40,  4'b0000, 32'h0,        1'b1, 1'b0, 32'hFFFF_FF80, 1'b1};
    vecs[3]  = '{"sh_102",     1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 5'd7,  32'h0,        0, 0, 1'b1, 30'h40,  4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{"lw_101",     1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        5'd4,  32'h0,        0, 0, 1'b0, 30'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[5]  = '{"lhu_002",    1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,        5'd6,  32'h9ABC_0000, 0, 5, 1'b1, 30'h0,   4'b0000, 32'h0,        1'b1, 1'b0, 32'h0000_9ABC, 1'b1};
    vecs[6]  = '{"sb_201",     1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 5'd0,  32'h0,        1, 0, 1'b1, 30'h80,  4'b0010, 32'h7878_7878, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{"sw_300",     1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd2,  32'h0,        0, 0, 1'b1, 30'hC0,  4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{"lh_402",     1'b1, 1'b0, 3'b001, 32'h0000_0402, 32'h0,        5'd9,  32'h8001_7FFF, 1, 2, 1'b1, 30'h100, 4'b0000, 32'h0,        1'b1, 1'b0, 32'hFFFF_8001, 1'b1};
    vecs[9]  = '{"lbu_501",    1'b1, 1'b0, 3'b100, 32'h0000_0501, 32'h0,        5'd10, 32'h0000_A500, 0, 1, 1'b1, 30'h140, 4'b0000, 32'h0,        1'b1, 1'b0, 32'h0000_00A5, 1'b1};
    vecs[10] = '{"lw_rd0",     1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0,        5'd0,  32'h1122_3344, 0, 0, 1'b1, 30'h180, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h1122_3344, 1'b1};
    vecs[11] = '{"sw_702",     1'b0, 1'b1, 3'b010, 32'h0000_0702, 32'h5555_5555, 5'd1,  32'h0,        0, 0, 1'b0, 30'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[12] = '{"sh_703",     1'b0, 1'b1, 3'b001, 32'h0000_0703, 32'h6666_6666, 5'd1,  32'h0,        0, 0, 1'b0, 30'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[13] = '{"lh_003",     1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0,        5'd8,  32'h0,        0, 0, 1'b0, 30'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[14] = '{"ld_f3_011",  1'b1, 1'b0, 3'b011, 32'h0000_0800, 32'h0,        5'd8,  32'h0,        0, 0, 1'b0, 30'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[15] = '{"st_f3_110",  1'b0, 1'b1, 3'b110, 32'h0000_0800, 32'h7777_7777, 5'd8,  32'h0,        0, 0, 1'b0, 30'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[16] = '{"lb_800",     1'b1, 1'b0, 3'b000, 32'h0000_0800, 32'h0,        5'd1,  32'h0000_007F, 0, 0, 1'b1, 30'h200, 4'b0000, 32'h0,        1'b1, 1'b0, 32'h0000_007F, 1'b1};
    vecs[17] = '{"lw_804",     1'b1, 1'b0, 3'b010, 32'h0000_0804, 32'h0,        5'd31, 32'hFFFF_FFFF, 0, 0, 1'b1, 30'h201, 4'b0000, 32'h0,        1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[18] = '{"sb_003",     1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 5'd3,  32'h0,        0, 0, 1'b1, 30'h0,   4'b1000, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[19] = '{"lhu_000",    1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0,        5'd12, 32'h1234_8765, 0, 0, 1'b1, 30'h0,   4'b0000, 32'h0,        1'b1, 1'b0, 32'h0000_8765, 1'b1};

    bus.in_valid   = 1'b0;
    bus.alu_out    = 32'h0;
    bus.store_data = 32'h0;
    bus.funct3     = 3'b000;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.rd         = 5'd0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = 32'h0;

    // Values held while reset is asserted.
    #2;
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_req_valid",  32'(bus.req_valid),  32'd0);
    check("rst_wb_valid",   32'(bus.wb_valid),   32'd0);
    check("rst_wb_we",      32'(bus.wb_we),      32'd0);
    check("rst_misaligned", 32'(bus.misaligned), 32'd0);
    check("rst_wb_rd",      32'(bus.wb_rd),      32'd0);
    check("rst_wb_data",    bus.wb_data,         32'd0);
    check("rst_req_addr",   32'(bus.req_addr),   32'd0);
    check("rst_req_wmask",  32'(bus.req_wmask),  32'd0);
    check("rst_req_wdata",  bus.req_wdata,       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table-driven ops.
    for (int i = 0; i < 20; i++) apply(vecs[i]);

    // A load response while idle is ignored.
    bus.resp_valid = 1'b1;
    bus.resp_data  = 32'hAAAA_AAAA;
    tick();
    bus.resp_valid = 1'b0;
    check("idle_resp_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_resp_no_wb",    32'(bus.wb_valid), 32'd0);

    // Reset while a store request is held.
    bus.in_valid = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010;
    bus.alu_out = 32'h0000_0A00; bus.store_data = 32'h0BAD_F00D; bus.rd = 5'd2;
    tick();
    bus.in_valid = 1'b0; bus.is_store = 1'b0;
    check("rreq_req_valid", 32'(bus.req_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rreq_req_drop",   32'(bus.req_valid), 32'd0);
    check("rreq_in_ready",   32'(bus.in_ready),  32'd1);
    check("rreq_wmask_zero", 32'(bus.req_wmask), 32'd0);
    check("rreq_wdata_zero", bus.req_wdata,      32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Reset while a load waits for its response; the late response is dropped.
    bus.in_valid = 1'b1; bus.is_load = 1'b1; bus.funct3 = 3'b010;
    bus.alu_out = 32'h0000_0900; bus.rd = 5'd11;
    tick();
    bus.in_valid = 1'b0; bus.is_load = 1'b0;
    check("rwait_req_valid", 32'(bus.req_valid), 32'd1);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check("rwait_in_wait", 32'(bus.in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rwait_in_ready",  32'(bus.in_ready), 32'd1);
    check("rwait_addr_zero", 32'(bus.req_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bus.resp_valid = 1'b1;
    bus.resp_data  = 32'h1357_9BDF;
    tick();
    bus.resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rwait_no_wb",    32'(bus.wb_valid), 32'd0);
      check("rwait_ready_up", 32'(bus.in_ready), 32'd1);
      tick();
    end
    check("rwait_wb_data_zero", bus.wb_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
